hs_ram_arbiter: RTL and testbench

//  Shares one game work-RAM port between the game CPU and the hiscore engine.
//  On a hiscore read/write intent it requests a CPU pause and waits for the pause

---
 rtl/hs_ram_arbiter_if.sv | 40 ++++
 rtl/hs_ram_arbiter.sv | 120 ++++++++++++
 tb/tb_hs_ram_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hs_ram_arbiter_if.sv
// RAM-port sharing bundle between the game CPU, the hiscore engine, the pause block
// and the core's synchronous work RAM.
interface hs_ram_arbiter_if #(
  parameter int AW = 11
);
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_we;
  logic [7:0]    cpu_dout;
  logic [AW-1:0] hs_address;
  logic [7:0]    hs_data_in;
  logic          hs_write_enable;
  logic          hs_read_intent;
  logic          hs_write_intent;
  logic [7:0]    hs_data_out;
  logic          hs_grant;
  logic          pause_req;
  logic          paused;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_dout;
  logic          hs_timeout;

  // Environment side: CPU, hiscore engine, pause block and RAM.
  modport master (
    output cpu_addr, cpu_din, cpu_we, hs_address, hs_data_in, hs_write_enable,
           hs_read_intent, hs_write_intent, paused, ram_dout,
    input  cpu_dout, hs_data_out, hs_grant, pause_req, ram_addr, ram_din, ram_we,
           hs_timeout
  );

  // Arbiter side.
  modport slave (
    input  cpu_addr, cpu_din, cpu_we, hs_address, hs_data_in, hs_write_enable,
           hs_read_intent, hs_write_intent, paused, ram_dout,
    output cpu_dout, hs_data_out, hs_grant, pause_req, ram_addr, ram_din, ram_we,
           hs_timeout
  );
endinterface

// File: rtl/hs_ram_arbiter.sv
// Pauses the game CPU, waits for a settle delay, lends the work-RAM port to the
// hiscore engine, then hands it back and releases the pause.
module hs_ram_arbiter #(
  parameter int AW      = 11,
  parameter int SETTLE  = 4,
  parameter int RELEASE = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  hs_ram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PAUSE_WAIT = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_GRANT      = 3'd3,
    ST_RELEASE    = 3'd4
  } state_t;

  localparam logic [9:0] WAIT_LAST    = 10'(TIMEOUT - 1);
  localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE - 1);
  localparam logic [3:0] RELEASE_LAST = 4'(RELEASE - 1);

  state_t     state_r;
  state_t     state_next;
  logic [9:0] wait_cnt_r;
  logic [3:0] cnt_r;
  logic       hs_grant_r;
  logic       pause_req_r;
  logic       hs_timeout_r;
  logic       timeout_hit;
  logic       req;

  assign req = bus.hs_read_intent | bus.hs_write_intent;

  // Next-state decode; a finished RELEASE always passes through IDLE before re-arming.
  always_comb begin
    state_next  = state_r;
    timeout_hit = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) state_next = ST_PAUSE_WAIT;
        else     state_next = ST_IDLE;
      end
      ST_PAUSE_WAIT: begin
        if (!req) begin
          state_next = ST_RELEASE;
        end else if (bus.paused) begin
          state_next = ST_SETTLE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_next  = ST_RELEASE;
          timeout_hit = 1'b1;
        end else begin
          state_next = ST_PAUSE_WAIT;
        end
      end
      ST_SETTLE: begin
        if (!req)                      state_next = ST_RELEASE;
        else if (!bus.paused)          state_next = ST_PAUSE_WAIT;
        else if (cnt_r == SETTLE_LAST) state_next = ST_GRANT;
        else                           state_next = ST_SETTLE;
      end
      ST_GRANT: begin
        if (!req) state_next = ST_RELEASE;
        else      state_next = ST_GRANT;
      end
      ST_RELEASE: begin
        if (cnt_r == RELEASE_LAST) state_next = ST_IDLE;
        else                       state_next = ST_RELEASE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, saturating counters (cleared on every state change) and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      wait_cnt_r   <= 10'd0;
      cnt_r        <= 4'd0;
      hs_grant_r   <= 1'b0;
      pause_req_r  <= 1'b0;
      hs_timeout_r <= 1'b0;
    end else begin
      state_r <= state_next;
      if (state_next != state_r) begin
        wait_cnt_r <= 10'd0;
        cnt_r      <= 4'd0;
      end else begin
        if (wait_cnt_r != 10'h3FF) wait_cnt_r <= wait_cnt_r + 10'd1;
        if (cnt_r != 4'hF)         cnt_r      <= cnt_r + 4'd1;
      end
      hs_grant_r  <= (state_next == ST_GRANT);
      pause_req_r <= (state_next != ST_IDLE);
      if (timeout_hit) hs_timeout_r <= 1'b1;
    end
  end

  // Port mux keyed on the registered grant, so a hiscore write can never leak through early.
  always_comb begin
    if (hs_grant_r) begin
      bus.ram_addr = bus.hs_address;
      bus.ram_din  = bus.hs_data_in;
      bus.ram_we   = bus.hs_write_enable & bus.hs_write_intent;
    end else begin
      bus.ram_addr = bus.cpu_addr;
      bus.ram_din  = bus.cpu_din;
      bus.ram_we   = bus.cpu_we;
    end
  end

  assign bus.cpu_dout    = bus.ram_dout;
  assign bus.hs_data_out = bus.ram_dout;
  assign bus.hs_grant    = hs_grant_r;
  assign bus.pause_req   = pause_req_r;
  assign bus.hs_timeout  = hs_timeout_r;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter: reset, read, write gating, release, timeout and
// asynchronous reset during a grant, against a behavioural 2 KB synchronous RAM.
module tb_hs_ram_arbiter;

  logic clk_sys;
  logic reset_n;
  int   total;
  int   bad;
  logic [7:0] mem [0:2047];

  hs_ram_arbiter_if #(.AW(11)) bus ();

  hs_ram_arbiter #(.AW(11), .SETTLE(4), .RELEASE(2), .TIMEOUT(1023)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Synchronous RAM, read-before-write, 1-cycle read latency.
  always @(posedge clk_sys) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  initial begin
    logic any_grant;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h010] = 8'hC3;
    reset_n              = 1'b0;
    bus.cpu_addr         = 11'h123;
    bus.cpu_din          = 8'h00;
    bus.cpu_we           = 1'b0;
    bus.hs_address       = 11'h000;
    bus.hs_data_in       = 8'h00;
    bus.hs_write_enable  = 1'b0;
    bus.hs_read_intent   = 1'b0;
    bus.hs_write_intent  = 1'b0;
    bus.paused           = 1'b0;

    // 1. Reset state and CPU pass-through.
    @(negedge clk_sys);
    check_eq("rst_grant", 32'(bus.hs_grant), 32'd0);
    check_eq("rst_pause", 32'(bus.pause_req), 32'd0);
    check_eq("rst_tmo", 32'(bus.hs_timeout), 32'd0);
    check_eq("rst_addr", 32'(bus.ram_addr), 32'h123);
    bus.cpu_we = 1'b1;
    #1;
    check_eq("rst_we", 32'(bus.ram_we), 32'd1);
    bus.cpu_we = 1'b0;
    #1;
    reset_n = 1'b1;
    @(negedge clk_sys);

    // 2. Read: paused arrives 3 cycles after pause_req; grant 4 cycles after it is seen.
    bus.hs_read_intent = 1'b1;
    tick();
    check_eq("rd_pause_rise", 32'(bus.pause_req), 32'd1);
    tick();
    tick();
    tick();
    bus.paused = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_eq("rd_grant_early", 32'(bus.hs_grant), 32'd0);
    tick();
    check_eq("rd_grant_on", 32'(bus.hs_grant), 32'd1);
    bus.hs_address = 11'h010;
    #1;
    check_eq("rd_addr_mux", 32'(bus.ram_addr), 32'h010);
    tick();
    check_eq("rd_data", 32'(bus.hs_data_out), 32'hC3);

    // 4. Release: grant drops on the next edge, pause two cycles later, CPU regains RAM.
    bus.hs_read_intent = 1'b0;
    tick();
    check_eq("rel_grant_off", 32'(bus.hs_grant), 32'd0);
    check_eq("rel_pause_hold1", 32'(bus.pause_req), 32'd1);
    check_eq("rel_cpu_addr", 32'(bus.ram_addr), 32'h123);
    tick();
    check_eq("rel_pause_hold2", 32'(bus.pause_req), 32'd1);
    tick();
    check_eq("rel_pause_off", 32'(bus.pause_req), 32'd0);
    bus.paused  = 1'b0;
    bus.cpu_addr = 11'h200;
    bus.cpu_din  = 8'h77;
    bus.cpu_we   = 1'b1;
    tick();
    bus.cpu_we   = 1'b0;
    check_eq("rel_cpu_write", 32'(mem[11'h200]), 32'h77);
    bus.cpu_addr = 11'h123;

    // 3. Write gating before grant, hiscore write during grant, CPU strobe ignored.
    bus.hs_write_intent = 1'b1;
    bus.hs_write_enable = 1'b1;
    bus.hs_address      = 11'h7FF;
    bus.hs_data_in      = 8'h5A;
    tick();
    check_eq("wr_gate_wait", 32'(bus.ram_we), 32'd0);
    bus.paused = 1'b1;
    tick();
    check_eq("wr_gate_settle", 32'(bus.ram_we), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("wr_grant_on", 32'(bus.hs_grant), 32'd1);
    bus.cpu_addr = 11'h100;
    bus.cpu_din  = 8'hEE;
    bus.cpu_we   = 1'b1;
    #1;
    check_eq("wr_ram_we", 32'(bus.ram_we), 32'd1);
    check_eq("wr_ram_din", 32'(bus.ram_din), 32'h5A);
    tick();
    bus.hs_write_enable = 1'b0;
    bus.cpu_we          = 1'b0;
    check_eq("wr_mem_hs", 32'(mem[11'h7FF]), 32'h5A);
    check_eq("wr_mem_cpu", 32'(mem[11'h100]), 32'h00);
    tick();
    check_eq("wr_readback", 32'(bus.hs_data_out), 32'h5A);
    bus.hs_write_intent = 1'b0;
    bus.cpu_addr        = 11'h123;
    tick();
    tick();
    tick();
    check_eq("wr_pause_off", 32'(bus.pause_req), 32'd0);
    bus.paused = 1'b0;

    // 5. Timeout: paused never arrives.
    bus.hs_read_intent = 1'b1;
    any_grant = 1'b0;
    tick();
    check_eq("tmo_pause_rise", 32'(bus.pause_req), 32'd1);
    for (int i = 0; i < 1022; i++) begin
      tick();
      any_grant = any_grant | bus.hs_grant;
    end
    check_eq("tmo_early", 32'(bus.hs_timeout), 32'd0);
    tick();
    check_eq("tmo_set", 32'(bus.hs_timeout), 32'd1);
    check_eq("tmo_pause_rel", 32'(bus.pause_req), 32'd1);
    bus.hs_read_intent = 1'b0;
    tick();
    check_eq("tmo_pause_hold", 32'(bus.pause_req), 32'd1);
    tick();
    check_eq("tmo_pause_off", 32'(bus.pause_req), 32'd0);
    check_eq("tmo_no_grant", 32'(any_grant | bus.hs_grant), 32'd0);
    check_eq("tmo_sticky", 32'(bus.hs_timeout), 32'd1);

    // 6. Asynchronous reset while the hiscore engine owns the port.
    bus.paused         = 1'b1;
    bus.hs_read_intent = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_eq("ar_grant_on", 32'(bus.hs_grant), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_grant_off", 32'(bus.hs_grant), 32'd0);
    check_eq("ar_pause_off", 32'(bus.pause_req), 32'd0);
    check_eq("ar_tmo_clr", 32'(bus.hs_timeout), 32'd0);
    check_eq("ar_cpu_addr", 32'(bus.ram_addr), 32'h123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
